// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array datapath blocks.
package systolic_pkg;

  localparam int unsigned DEF_PSUM_WIDTH = 32;
  localparam int unsigned DEF_NUM_COL    = 4;

  // Width of one column slice of a psum row.
  localparam int unsigned COL_SLICE_W    = DEF_PSUM_WIDTH;

  // Drain controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/psum_row_fifo.sv
// First-word-fall-through row FIFO. Full/empty come from an extra wrap bit
// on each pointer. A write on a full FIFO is accepted only when a read
// happens in the same cycle.
module psum_row_fifo #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              wr_fire, rd_fire;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_fire = rd_en && !empty;
  assign wr_fire = wr_en && (!full || rd_fire);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Storage and pointer registers; storage is cleared so the read port is 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Deskews bottom-row psums of the systolic array into aligned rows, buffers
// them in a FIFO, streams them out over valid/ready and counts rows per job.
// Optional macro PSUM_DRAIN_RELU_EN: clamp negative output columns to zero.
module psum_drain
  import systolic_pkg::*;
#(
  parameter int unsigned NUM_COL       = DEF_NUM_COL,
  parameter int unsigned PSUM_WIDTH    = COL_SLICE_W,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ROW_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROW_CNT_WIDTH-1:0]      num_rows,
  input  logic [NUM_COL-1:0]            col_valid,
  input  logic [NUM_COL*PSUM_WIDTH-1:0] psum_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_COL*PSUM_WIDTH-1:0] out_data,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic                          skew_err
);

  localparam int unsigned ROW_W = NUM_COL * PSUM_WIDTH;

  logic [NUM_COL-1:0]       al_valid;
  logic [ROW_W-1:0]         al_data;
  drain_state_e             state_q, state_d;
  logic [ROW_CNT_WIDTH-1:0] target_q, target_d;
  logic [ROW_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     skew_q, skew_d;
  logic                     busy_q, done_q;
  logic                     push_c;
  logic                     fifo_full, fifo_empty;
  logic [ROW_W-1:0]         fifo_rd;

  // Deskew: column c is delayed NUM_COL-c cycles so all columns line up.
  for (genvar c = 0; c < int'(NUM_COL); c++) begin : g_deskew
    localparam int unsigned STG = NUM_COL - c;
    logic [PSUM_WIDTH-1:0] dat_q [STG];
    logic [STG-1:0]        vld_q;

    // Data/valid shift line, running in every state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        for (int s = 0; s < int'(STG); s++) dat_q[s] <= '0;
      end else begin
        vld_q[0] <= col_valid[c];
        dat_q[0] <= psum_in[c*PSUM_WIDTH +: PSUM_WIDTH];
        for (int s = 1; s < int'(STG); s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign al_valid[c]                            = vld_q[STG-1];
    assign al_data[c*PSUM_WIDTH +: PSUM_WIDTH]    = dat_q[STG-1];
  end

  // Column 0 defines a row; rows arriving outside RUN are discarded.
  assign push_c = (state_q == ST_RUN) && al_valid[0];

  psum_row_fifo #(
    .DATA_W (ROW_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_c),
    .wr_data (al_data),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state, row counting and sticky error flags.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    skew_d   = skew_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          target_d = num_rows;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          skew_d   = 1'b0;
        end
      end
      ST_RUN:   if (cnt_q == target_q) state_d = ST_FLUSH;
      ST_FLUSH: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Every push counts, even a dropped one, since the array cannot stall.
    if (push_c) begin
      cnt_d = cnt_q + ROW_CNT_WIDTH'(1);
      if (al_valid != {NUM_COL{1'b1}}) skew_d = 1'b1;
      if (fifo_full && !out_ready)     ovf_d  = 1'b1;
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      skew_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      skew_q   <= skew_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign out_valid = !fifo_empty;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign skew_err  = skew_q;

`ifdef PSUM_DRAIN_RELU_EN
  // Read-side ReLU: a set sign bit forces the column to zero.
  for (genvar c = 0; c < int'(NUM_COL); c++) begin : g_relu
    assign out_data[c*PSUM_WIDTH +: PSUM_WIDTH] =
      fifo_rd[c*PSUM_WIDTH + PSUM_WIDTH - 1] ? '0 : fifo_rd[c*PSUM_WIDTH +: PSUM_WIDTH];
  end
`else
  assign out_data = fifo_rd;
`endif

endmodule
